// File: rtl/mem_responder_sram.sv
// SRAM-backed target for the mem_req/mem_gnt protocol: optional wait states, external stall,
// and an error response for out-of-range or misaligned addresses.
module mem_responder_sram #(
  parameter int                    MEM_ADDR_W  = 64,
  parameter int                    MEM_DATA_W  = 64,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                    f_clk,
  input  logic                    g_resetn,
  input  logic                    mem_req,
  input  logic [MEM_ADDR_W-1:0]   mem_addr,
  input  logic                    mem_wen,
  input  logic [MEM_DATA_W/8-1:0] mem_strb,
  input  logic [MEM_DATA_W-1:0]   mem_wdata,
  input  logic                    stall,
  output logic                    mem_gnt,
  output logic                    mem_err,
  output logic [MEM_DATA_W-1:0]   mem_rdata,
  output logic [1:0]              dbg_state
);

  // Handshake: the initiator raises mem_req and holds it, with address/control/data stable,
  // until it sees the one-cycle mem_gnt pulse; mem_err and mem_rdata are valid only with mem_gnt.

  localparam int STRB_W = MEM_DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [MEM_ADDR_W-1:0] SPAN       = MEM_ADDR_W'(DEPTH_WORDS * STRB_W);
  localparam logic [MEM_ADDR_W-1:0] ALIGN_MASK = MEM_ADDR_W'(STRB_W - 1);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0]   off;
  logic                    addr_err;
  logic [IDX_W-1:0]        idx;
  logic                    do_access;
  logic [MEM_DATA_W-1:0]   mem [DEPTH_WORDS];

  assign off       = mem_addr - BASE_ADDR;
  assign addr_err  = (mem_addr < BASE_ADDR) || (off >= SPAN) || ((mem_addr & ALIGN_MASK) != '0);
  assign idx       = IDX_W'(off >> OFF_W);
  assign do_access = (state_q == ACTIVE) && mem_req && (cnt_q == 4'd0) && !stall;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d = ACTIVE;
          cnt_d   = WAIT_INIT;
        end
      end
      ACTIVE: begin
        // A dropped request abandons the access; stall only counts once wait states are spent.
        if (!mem_req)            state_d = IDLE;
        else if (cnt_q != 4'd0)  cnt_d   = cnt_q - 4'd1;
        else if (!stall)         state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      mem_gnt   <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_gnt   <= do_access;
      mem_err   <= do_access && addr_err;
      mem_rdata <= (do_access && !addr_err && !mem_wen) ? mem[idx] : '0;
    end
  end

  // Array contents survive reset; writes commit only on the granting edge.
  always_ff @(posedge f_clk) begin
    if (do_access && !addr_err && mem_wen) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (mem_strb[i]) mem[idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder_sram.sv
// Bench for mem_responder_sram: two instances (no wait states / three wait states) on shared
// request buses, with expected responses (grant cycle, error, read data) queued per instance.
module tb_mem_responder_sram;

  localparam int EW = 32 + 1 + 64;

  logic        clk;
  logic        rst_a, rst_b;
  logic        req_a, req_b;
  logic [63:0] addr;
  logic        wen;
  logic [7:0]  strb;
  logic [63:0] wdata;
  logic        stall;
  logic        gnt_a, err_a, gnt_b, err_b;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  dbg_a, dbg_b;
  logic [31:0] cyc;

  logic [EW-1:0] exp_q_a[$];
  logic [EW-1:0] exp_q_b[$];
  int n_vec;
  int n_miss;

  mem_responder_sram #(.BASE_ADDR(64'h1000), .WAIT_CYCLES(0)) dut_a (
    .f_clk(clk), .g_resetn(rst_a), .mem_req(req_a), .mem_addr(addr), .mem_wen(wen),
    .mem_strb(strb), .mem_wdata(wdata), .stall(stall), .mem_gnt(gnt_a), .mem_err(err_a),
    .mem_rdata(rdata_a), .dbg_state(dbg_a)
  );

  mem_responder_sram #(.BASE_ADDR(64'h1000), .WAIT_CYCLES(3)) dut_b (
    .f_clk(clk), .g_resetn(rst_b), .mem_req(req_b), .mem_addr(addr), .mem_wen(wen),
    .mem_strb(strb), .mem_wdata(wdata), .stall(stall), .mem_gnt(gnt_b), .mem_err(err_b),
    .mem_rdata(rdata_b), .dbg_state(dbg_b)
  );

  // Clock / reset-independent cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: compare every grant against the head of its queue, including the grant cycle.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (gnt_a === 1'b1) begin
      n_vec++;
      if (exp_q_a.size() == 0) begin
        n_miss++;
        $display("FAIL a_unexpected_gnt cycle=%0d err=%0b rdata=%h", cyc, err_a, rdata_a);
      end else begin
        e = exp_q_a.pop_front();
        if ({cyc, err_a, rdata_a} !== e) begin
          n_miss++;
          $display("FAIL a_resp got cyc=%0d err=%0b rdata=%h exp cyc=%0d err=%0b rdata=%h",
                   cyc, err_a, rdata_a, e[96:65], e[64], e[63:0]);
        end
      end
    end else if (gnt_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== 64'h0) begin
      n_vec++;
      n_miss++;
      $display("FAIL a_idle_out cycle=%0d gnt=%b err=%b rdata=%h exp 0", cyc, gnt_a, err_a, rdata_a);
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (gnt_b === 1'b1) begin
      n_vec++;
      if (exp_q_b.size() == 0) begin
        n_miss++;
        $display("FAIL b_unexpected_gnt cycle=%0d err=%0b rdata=%h", cyc, err_b, rdata_b);
      end else begin
        e = exp_q_b.pop_front();
        if ({cyc, err_b, rdata_b} !== e) begin
          n_miss++;
          $display("FAIL b_resp got cyc=%0d err=%0b rdata=%h exp cyc=%0d err=%0b rdata=%h",
                   cyc, err_b, rdata_b, e[96:65], e[64], e[63:0]);
        end
      end
    end else if (gnt_b !== 1'b0 || err_b !== 1'b0 || rdata_b !== 64'h0) begin
      n_vec++;
      n_miss++;
      $display("FAIL b_idle_out cycle=%0d gnt=%b err=%b rdata=%h exp 0", cyc, gnt_b, err_b, rdata_b);
    end
  end

  // Driver: request on instance which (0=a, 1=b); stall_mask bit k drives stall in cycle t+k;
  // lat is the hand-computed grant latency in cycles.
  task automatic issue(input bit which, input logic w, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d, input logic e_err, input logic [63:0] e_rdata,
                       input logic [31:0] stall_mask, input int lat);
    logic [31:0] t;
    t = cyc;
    if (which) exp_q_b.push_back({t + 32'(lat), e_err, e_rdata});
    else       exp_q_a.push_back({t + 32'(lat), e_err, e_rdata});
    wen = w; addr = a; strb = s; wdata = d;
    if (which) req_b = 1'b1; else req_a = 1'b1;
    for (int k = 0; k <= lat; k++) begin
      stall = stall_mask[k];
      @(posedge clk); #1;
    end
    req_a = 1'b0; req_b = 1'b0; stall = 1'b0;
  endtask

  task automatic check_zero(input string name, input logic g, input logic er, input logic [63:0] rd);
    n_vec++;
    if (g !== 1'b0 || er !== 1'b0 || rd !== 64'h0) begin
      n_miss++;
      $display("FAIL %s gnt=%b err=%b rdata=%h exp all 0", name, g, er, rd);
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_a = 1'b0; rst_b = 1'b0; stall = 1'b0; req_b = 1'b0;
    // Request held through reset must not be served while reset is low.
    req_a = 1'b1; wen = 1'b1; addr = 64'h1008; strb = 8'hFF; wdata = 64'h1122334455667788;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("reset_hold_a", gnt_a, err_a, rdata_a);
      check_zero("reset_hold_b", gnt_b, err_b, rdata_b);
    end
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;

    // Instance a: zero wait states, base 0x1000
    issue(0, 1, 64'h1008, 8'hFF, 64'h1122334455667788, 0, 64'h0, 0, 2);
    issue(0, 1, 64'h1008, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 64'h0, 0, 2);
    issue(0, 0, 64'h1008, 8'h00, 64'h0, 0, 64'h11223344AAAAAAAA, 0, 2);
    issue(0, 0, 64'h0FF8, 8'h00, 64'h0, 1, 64'h0, 0, 2);
    issue(0, 1, 64'h3000, 8'hFF, 64'h5555555555555555, 1, 64'h0, 0, 2);
    issue(0, 0, 64'h100C, 8'h00, 64'h0, 1, 64'h0, 0, 2);
    issue(0, 0, 64'h1008, 8'h00, 64'h0, 0, 64'h11223344AAAAAAAA, 0, 2);
    issue(0, 1, 64'h2FF8, 8'hFF, 64'hCAFEF00DDEADBEEF, 0, 64'h0, 0, 2);
    issue(0, 0, 64'h2FF8, 8'h00, 64'h0, 0, 64'hCAFEF00DDEADBEEF, 0, 2);
    issue(0, 1, 64'h1010, 8'hFF, 64'h0123456789ABCDEF, 0, 64'h0, 0, 2);
    issue(0, 1, 64'h1010, 8'h00, 64'hFFFFFFFFFFFFFFFF, 0, 64'h0, 0, 2);
    // stall for two cycles once ACTIVE, with an odd lane pattern
    issue(0, 1, 64'h1010, 8'h81, 64'h11000000000000FF, 0, 64'h0, 32'b0110, 4);
    issue(0, 0, 64'h1010, 8'h00, 64'h0, 0, 64'h1123456789ABCDFF, 0, 2);

    // Abort on a: stalled write to 0x1010 withdrawn before grant
    req_a = 1'b1; wen = 1'b1; addr = 64'h1010; strb = 8'hFF; wdata = 64'hDEADDEADDEADDEAD; stall = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    issue(0, 0, 64'h1010, 8'h00, 64'h0, 0, 64'h1123456789ABCDFF, 0, 2);

    // Reset mid-op on a: committed write persists, pending write is dropped
    issue(0, 1, 64'h1018, 8'hFF, 64'h0F0F0F0F0F0F0F0F, 0, 64'h0, 0, 2);
    req_a = 1'b1; wen = 1'b1; addr = 64'h1018; strb = 8'hFF; wdata = 64'h7777777777777777; stall = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    check_zero("reset_mid_a", gnt_a, err_a, rdata_a);
    n_vec++;
    if (dbg_a !== 2'd0) begin
      n_miss++;
      $display("FAIL reset_mid_state got=%0d exp=0", dbg_a);
    end
    req_a = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    issue(0, 0, 64'h1018, 8'h00, 64'h0, 0, 64'h0F0F0F0F0F0F0F0F, 0, 2);

    // Instance b: three wait states
    issue(1, 1, 64'h1000, 8'hFF, 64'hA5A5A5A55A5A5A5A, 0, 64'h0, 0, 5);
    issue(1, 0, 64'h1000, 8'h00, 64'h0, 0, 64'hA5A5A5A55A5A5A5A, 32'b0011_0000, 7);
    issue(1, 0, 64'h1000, 8'h00, 64'h0, 0, 64'hA5A5A5A55A5A5A5A, 32'b0000_1110, 5);
    issue(1, 0, 64'h1004, 8'h00, 64'h0, 1, 64'h0, 0, 5);
    // Abort on b during the wait-state countdown
    req_b = 1'b1; wen = 1'b1; addr = 64'h1000; strb = 8'hFF; wdata = 64'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_b = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    issue(1, 0, 64'h1000, 8'h00, 64'h0, 0, 64'hA5A5A5A55A5A5A5A, 0, 5);

    repeat (4) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q_a.size() != 0) begin
      n_miss++;
      $display("FAIL a_missing_gnt pending=%0d exp=0", exp_q_a.size());
    end
    n_vec++;
    if (exp_q_b.size() != 0) begin
      n_miss++;
      $display("FAIL b_missing_gnt pending=%0d exp=0", exp_q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
